tlb_write_ctrl: RTL
===================

// Module: tlb_write_ctrl
// PURPOSE
//   Executes TLBWR / TLBFILL: the CSR->TLB direction of the path that TLBRD uses to load TLBEHI/TLBELO0/TLBELO1.
//   Captures TLBIDX, TLBEHI, TLBELO0, TLBELO1, ASID and the refill-exception flag on a commit pulse.
//   Selects the target entry (TLBIDX.index or a free-running fill index) and drives one write to the TLB array.
//   Ready/valid handshake with the array; busy/done handshake with commit.
// PARAMETERS
//   TLBNUM  16  number of TLB entries (power of two)
//   IDX_W   4   index width, log2(TLBNUM)
// PORTS
//   clk            in   1      clock
//   rst            in   1      synchronous, active-high reset
//   TLBWR_en       in   1      1-cycle pulse from commit: write entry at TLBIDX.index
//   TLBFILL_en     in   1      1-cycle pulse from commit: write entry at fill index
//   TLBIDX         in   32     [31]=NE, [29:24]=PS, [IDX_W-1:0]=index
//   TLBEHI         in   32     [31:13]=VPPN
//   TLBELO0        in   32     [27:8]=PPN, [6]=G, [5:4]=MAT, [3:2]=PLV, [1]=D, [0]=V
//   TLBELO1        in   32     same layout as TLBELO0
//   ASID           in   10     current ASID
//   refill_ex      in   1      ESTAT.Ecode==0x3F (in TLB refill handler)
//   tlb_w_ready    in   1      TLB array accepts write this cycle
//   tlb_we         out  1      write valid to TLB array
//   tlb_w_index    out  IDX_W  target entry
//   tlb_w_e        out  1      entry exist bit
//   tlb_w_vppn     out  19     VPPN
//   tlb_w_ps       out  6      page size
//   tlb_w_g        out  1      global = G0 & G1
//   tlb_w_asid     out  10     ASID
//   tlb_w_ppn0/1   out  20     PPN per half
//   tlb_w_mat0/1   out  2      MAT per half
//   tlb_w_plv0/1   out  2      PLV per half
//   tlb_w_d0/1     out  1      dirty per half
//   tlb_w_v0/1     out  1      valid per half
//   busy           out  1      request in flight; new pulses ignored
//   done           out  1      1-cycle pulse: write accepted by array
// BEHAVIOUR
//   Reset: state=IDLE, all outputs 0, fill_cnt=0; rst mid-operation aborts, tlb_we drops next cycle, no done.
//   fill_cnt: IDX_W-bit counter, +1 every cycle, wraps TLBNUM-1 -> 0; never held.
//   FSM IDLE -> WRITE -> DONE -> IDLE.
//   IDLE: on TLBWR_en|TLBFILL_en at edge T, capture all fields into output regs, go WRITE.
//     index = TLBWR_en ? TLBIDX[IDX_W-1:0] : fill_cnt value at edge T.
//     Both pulses same cycle: TLBWR wins, TLBFILL dropped.
//     e = refill_ex ? 1 : ~TLBIDX[31]; ps = TLBIDX[29:24]; vppn = TLBEHI[31:13]; g = ELO0[6] & ELO1[6].
//     ppn/mat/plv/d/v from ELO0 -> *0, ELO1 -> *1. Captured values held stable until next capture.
//   WRITE: tlb_we=1, busy=1; stays while tlb_w_ready=0; on tlb_w_ready=1 at edge, go DONE (tlb_we=0 next cycle).
//   DONE: done=1, busy=1 for exactly one cycle, then IDLE.
//   Minimum latency: pulse at T -> tlb_we in T+1 -> done in T+2 (ready=1 immediately).
//   Pulses during WRITE/DONE ignored (commit must hold on busy); pulse in IDLE cycle after DONE accepted.
//   tlb_we and done never high in the same cycle.
// TESTING
//   TLBWR_en, TLBIDX=0x0A00_0005, EHI=0x1234_6000, ELO0=0x0001_2347, ELO1=0x0005_6741, ready=1 -> T+1 tlb_we, idx=5, e=1, ps=0x0A, vppn=0x091A3, ppn0=0x00123, v0=1,d0=1,plv0=1,mat0=0, g=1; done T+2.
//   TLBWR with NE=1, refill_ex=0 -> tlb_w_e=0; same with refill_ex=1 -> tlb_w_e=1; ELO0.G=1, ELO1.G=0 -> g=0.
//   TLBFILL_en pulses at cycles 3 and 20 after reset (TLBNUM=16) -> indices 3 and 4 (20 mod 16); counter wraps 15->0.
//   tlb_w_ready low 4 cycles -> tlb_we held 4+1 cycles, fields stable, single done; TLBWR pulse while busy ignored.
//   TLBWR_en & TLBFILL_en same cycle -> index from TLBIDX; rst asserted while in WRITE -> tlb_we=0, busy=0, no done.

Source files
------------

// File: rtl/tlb_write_ctrl.sv
// TLBWR/TLBFILL write path: captures the CSR image on a commit pulse and
// drives one ready/valid write into the TLB array, then pulses done.
module tlb_write_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             TLBWR_en,
  input  logic             TLBFILL_en,
  input  logic [31:0]      TLBIDX,
  input  logic [31:0]      TLBEHI,
  input  logic [31:0]      TLBELO0,
  input  logic [31:0]      TLBELO1,
  input  logic [9:0]       ASID,
  input  logic             refill_ex,
  input  logic             tlb_w_ready,
  output logic             tlb_we,
  output logic [IDX_W-1:0] tlb_w_index,
  output logic             tlb_w_e,
  output logic [18:0]      tlb_w_vppn,
  output logic [5:0]       tlb_w_ps,
  output logic             tlb_w_g,
  output logic [9:0]       tlb_w_asid,
  output logic [19:0]      tlb_w_ppn0,
  output logic [19:0]      tlb_w_ppn1,
  output logic [1:0]       tlb_w_mat0,
  output logic [1:0]       tlb_w_mat1,
  output logic [1:0]       tlb_w_plv0,
  output logic [1:0]       tlb_w_plv1,
  output logic             tlb_w_d0,
  output logic             tlb_w_d1,
  output logic             tlb_w_v0,
  output logic             tlb_w_v1,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  mat0;
    logic [1:0]  mat1;
    logic [1:0]  plv0;
    logic [1:0]  plv1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } entry_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  entry_t           ent_q, ent_d;

  // Fields of the CSR image that the TLB entry does not carry.
  logic unused_bits;
  assign unused_bits = ^{TLBIDX[30], TLBIDX[23:IDX_W], TLBEHI[12:0],
                         TLBELO0[31:28], TLBELO0[7], TLBELO1[31:28], TLBELO1[7]};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ent_d      = ent_q;
    // TLBNUM is a power of two, so natural overflow gives the wrap.
    fill_cnt_d = fill_cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (TLBWR_en || TLBFILL_en) begin
          idx_d      = TLBWR_en ? TLBIDX[IDX_W-1:0] : fill_cnt_q;
          ent_d.e    = refill_ex | ~TLBIDX[31];
          ent_d.vppn = TLBEHI[31:13];
          ent_d.ps   = TLBIDX[29:24];
          ent_d.g    = TLBELO0[6] & TLBELO1[6];
          ent_d.asid = ASID;
          ent_d.ppn0 = TLBELO0[27:8];
          ent_d.ppn1 = TLBELO1[27:8];
          ent_d.mat0 = TLBELO0[5:4];
          ent_d.mat1 = TLBELO1[5:4];
          ent_d.plv0 = TLBELO0[3:2];
          ent_d.plv1 = TLBELO1[3:2];
          ent_d.d0   = TLBELO0[1];
          ent_d.d1   = TLBELO1[1];
          ent_d.v0   = TLBELO0[0];
          ent_d.v1   = TLBELO1[0];
          state_d    = WRITE;
        end
      end
      WRITE:   if (tlb_w_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      idx_q      <= '0;
      ent_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      idx_q      <= idx_d;
      ent_q      <= ent_d;
    end
  end

  assign tlb_we      = (state_q == WRITE);
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign tlb_w_index = idx_q;
  assign tlb_w_e     = ent_q.e;
  assign tlb_w_vppn  = ent_q.vppn;
  assign tlb_w_ps    = ent_q.ps;
  assign tlb_w_g     = ent_q.g;
  assign tlb_w_asid  = ent_q.asid;
  assign tlb_w_ppn0  = ent_q.ppn0;
  assign tlb_w_ppn1  = ent_q.ppn1;
  assign tlb_w_mat0  = ent_q.mat0;
  assign tlb_w_mat1  = ent_q.mat1;
  assign tlb_w_plv0  = ent_q.plv0;
  assign tlb_w_plv1  = ent_q.plv1;
  assign tlb_w_d0    = ent_q.d0;
  assign tlb_w_d1    = ent_q.d1;
  assign tlb_w_v0    = ent_q.v0;
  assign tlb_w_v1    = ent_q.v1;

endmodule
